// File: rtl/siren_gen.sv
// Multi-mode square-wave tone generator (silence / steady / two-tone / sweep) for the speaker pin.
// Latency: from silence, out rises TONE_LO clocks after mode is sampled; otherwise switches at the next falling boundary.
// Backpressure: none; mode is sampled only at falling boundaries (or any edge while silent).
module siren_gen #(
    parameter int HP_W       = 20,
    parameter int TONE_LO    = 113636,
    parameter int TONE_HI    = 75758,
    parameter int SEG_W      = 27,
    parameter int SEG_LEN    = 50000000,
    parameter int SWEEP_STEP = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    output logic       out,
    output logic [1:0] active_mode,
    output logic       tone_edge
);

    localparam int HPX = HP_W + 1;

    localparam logic [HP_W-1:0]  LO       = HP_W'(TONE_LO);
    localparam logic [HP_W-1:0]  HI       = HP_W'(TONE_HI);
    localparam logic [HP_W-1:0]  STEP     = HP_W'(SWEEP_STEP);
    localparam logic [HPX-1:0]   LO_X     = HPX'(TONE_LO);
    localparam logic [HPX-1:0]   HI_X     = HPX'(TONE_HI);
    localparam logic [HPX-1:0]   STEP_X   = HPX'(SWEEP_STEP);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_LEN - 1);

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    logic [HP_W-1:0]  hp_cnt;
    logic [HP_W-1:0]  cur_hp;
    logic [SEG_W-1:0] seg_cnt;
    logic             seg_sel;
    logic             sweep_dir;

    logic             boundary;
    logic             falling;
    logic [HPX-1:0]   hp_ext;
    logic [HP_W-1:0]  sweep_hp;
    logic             sweep_dir_nxt;

    assign boundary = (active_mode != 2'd0) && (hp_cnt == cur_hp - HP_W'(1));
    assign falling  = boundary && out;
    assign hp_ext   = {1'b0, cur_hp};

    // Clamp tests run before the step so a down-step can never wrap below zero.
    always_comb begin
        sweep_hp      = cur_hp;
        sweep_dir_nxt = sweep_dir;
        if (sweep_dir == DIR_DOWN) begin
            if (hp_ext <= HI_X + STEP_X) begin
                sweep_hp      = HI;
                sweep_dir_nxt = DIR_UP;
            end else begin
                sweep_hp = cur_hp - STEP;
            end
        end else begin
            if (hp_ext + STEP_X >= LO_X) begin
                sweep_hp      = LO;
                sweep_dir_nxt = DIR_DOWN;
            end else begin
                sweep_hp = cur_hp + STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out         <= 1'b0;
            active_mode <= 2'd0;
            tone_edge   <= 1'b0;
            hp_cnt      <= '0;
            seg_cnt     <= '0;
            seg_sel     <= 1'b0;
            sweep_dir   <= DIR_DOWN;
            cur_hp      <= LO;
        end else begin
            tone_edge <= 1'b0;
            if (active_mode == 2'd0) begin
                if (mode != 2'd0) begin
                    active_mode <= mode;
                    hp_cnt      <= '0;
                    seg_cnt     <= '0;
                    seg_sel     <= 1'b0;
                    sweep_dir   <= DIR_DOWN;
                    cur_hp      <= LO;
                end
            end else if (falling && (mode != active_mode)) begin
                // Switch only as out falls so no truncated high pulse reaches the speaker.
                active_mode <= mode;
                out         <= 1'b0;
                tone_edge   <= 1'b1;
                hp_cnt      <= '0;
                seg_cnt     <= '0;
                seg_sel     <= 1'b0;
                sweep_dir   <= DIR_DOWN;
                cur_hp      <= LO;
            end else begin
                if (active_mode == 2'd2) begin
                    if (seg_cnt == SEG_LAST) begin
                        seg_cnt <= '0;
                        seg_sel <= ~seg_sel;
                    end else begin
                        seg_cnt <= seg_cnt + SEG_W'(1);
                    end
                end
                if (boundary) begin
                    hp_cnt    <= '0;
                    out       <= ~out;
                    tone_edge <= 1'b1;
                    if (out) begin
                        case (active_mode)
                            2'd2: cur_hp <= seg_sel ? HI : LO;
                            2'd3: begin
                                cur_hp    <= sweep_hp;
                                sweep_dir <= sweep_dir_nxt;
                            end
                            default: cur_hp <= cur_hp;
                        endcase
                    end
                end else begin
                    hp_cnt <= hp_cnt + HP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_siren_gen.sv
// Directed bench for siren_gen with TONE_LO=10, TONE_HI=6, SEG_LEN=50, SWEEP_STEP=2.
module tb_siren_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       out;
    logic [1:0] active_mode;
    logic       tone_edge;

    int checks = 0;
    int errors = 0;

    siren_gen #(
        .HP_W       (20),
        .TONE_LO    (10),
        .TONE_HI    (6),
        .SEG_W      (27),
        .SEG_LEN    (50),
        .SWEEP_STEP (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .out         (out),
        .active_mode (active_mode),
        .tone_edge   (tone_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts negedge samples until out changes; -1 if the budget expires.
    task automatic wait_toggle(input int budget, output int cycles);
        logic prev;
        prev   = out;
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (out !== prev) return;
            if (cycles >= budget) begin
                cycles = -1;
                return;
            end
        end
    endtask

    // Leaves the bench at the sample just after the edge that loaded m.
    task automatic apply_reset(input logic [1:0] m);
        mode  = m;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        int c;
        rst_n = 1'b0;
        mode  = 2'd1;
        repeat (5) @(negedge clk);
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %0b want 0", out); end
        checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", active_mode); end
        checks++; if (tone_edge !== 1'b0) begin errors++; $display("FAIL reset_edge: got %0b want 0", tone_edge); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (active_mode !== 2'd1) begin errors++; $display("FAIL release_mode: got %0d want 1", active_mode); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL release_out: got %0b want 0", out); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL first_rise: got %0d want 10", c); end
        checks++; if (tone_edge !== 1'b1) begin errors++; $display("FAIL rise_edge: got %0b want 1", tone_edge); end
        @(negedge clk);
        checks++; if (tone_edge !== 1'b0) begin errors++; $display("FAIL edge_pulse_len: got %0b want 0", tone_edge); end
        wait_toggle(40, c);
        checks++; if (c !== 9) begin errors++; $display("FAIL steady_high: got %0d want 9", c); end
        checks++; if (tone_edge !== 1'b1) begin errors++; $display("FAIL fall_edge: got %0b want 1", tone_edge); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL steady_low: got %0d want 10", c); end
    endtask

    // Continues from test_reset: out has just risen in mode 1.
    task automatic test_deferred_switch;
        int c;
        repeat (3) @(negedge clk);
        mode = 2'd3;
        @(negedge clk);
        checks++; if (active_mode !== 2'd1) begin errors++; $display("FAIL defer_hold: got %0d want 1", active_mode); end
        wait_toggle(40, c);
        checks++; if (c !== 6) begin errors++; $display("FAIL defer_high_rest: got %0d want 6", c); end
        checks++; if (active_mode !== 2'd3) begin errors++; $display("FAIL defer_switch: got %0d want 3", active_mode); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL defer_out: got %0b want 0", out); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL defer_low: got %0d want 10", c); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL defer_high: got %0d want 10", c); end
        wait_toggle(40, c);
        checks++; if (c !== 8) begin errors++; $display("FAIL defer_sweep_step: got %0d want 8", c); end
    endtask

    task automatic test_two_tone;
        int c;
        int exp_hp [16] = '{10, 10, 10, 10, 10, 10, 6, 6, 6, 6, 6, 6, 6, 6, 10, 10};
        apply_reset(2'd2);
        checks++; if (active_mode !== 2'd2) begin errors++; $display("FAIL two_tone_mode: got %0d want 2", active_mode); end
        for (int i = 0; i < 16; i++) begin
            wait_toggle(40, c);
            checks++;
            if (c !== exp_hp[i]) begin
                errors++;
                $display("FAIL two_tone_half[%0d]: got %0d want %0d", i, c, exp_hp[i]);
            end
        end
    endtask

    task automatic test_sweep;
        int c;
        int exp_hp [14] = '{10, 10, 8, 8, 6, 6, 8, 8, 10, 10, 8, 8, 6, 6};
        apply_reset(2'd3);
        checks++; if (active_mode !== 2'd3) begin errors++; $display("FAIL sweep_mode: got %0d want 3", active_mode); end
        for (int i = 0; i < 14; i++) begin
            wait_toggle(40, c);
            checks++;
            if (c !== exp_hp[i]) begin
                errors++;
                $display("FAIL sweep_half[%0d]: got %0d want %0d", i, c, exp_hp[i]);
            end
        end
    endtask

    task automatic test_silence;
        int c;
        int bad;
        apply_reset(2'd2);
        repeat (3) wait_toggle(40, c);
        mode = 2'd0;
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL silence_fall: got %0d want 10", c); end
        checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL silence_mode: got %0d want 0", active_mode); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL silence_out: got %0b want 0", out); end
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (out !== 1'b0 || tone_edge !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL silence_quiet: got %0d active samples want 0", bad); end
        mode = 2'd1;
        @(negedge clk);
        checks++; if (active_mode !== 2'd1) begin errors++; $display("FAIL wake_mode: got %0d want 1", active_mode); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL wake_rise: got %0d want 10", c); end
        repeat (2) @(negedge clk);
        mode = 2'd2;
        repeat (2) @(negedge clk);
        mode = 2'd1;
        wait_toggle(40, c);
        checks++; if (c !== 6) begin errors++; $display("FAIL glitch_fall: got %0d want 6", c); end
        checks++; if (active_mode !== 2'd1) begin errors++; $display("FAIL glitch_ignored: got %0d want 1", active_mode); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL glitch_low: got %0d want 10", c); end
    endtask

    task automatic test_async_reset;
        int c;
        apply_reset(2'd3);
        wait_toggle(40, c);
        repeat (3) @(negedge clk);
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL async_pre_high: got %0b want 1", out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL async_out: got %0b want 0", out); end
        checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL async_mode: got %0d want 0", active_mode); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (active_mode !== 2'd3) begin errors++; $display("FAIL async_restart_mode: got %0d want 3", active_mode); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL async_restart_low: got %0d want 10", c); end
        wait_toggle(40, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL async_restart_high: got %0d want 10", c); end
        wait_toggle(40, c);
        checks++; if (c !== 8) begin errors++; $display("FAIL async_restart_step: got %0d want 8", c); end
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 2'd0;
        test_reset();
        test_deferred_switch();
        test_two_tone();
        test_sweep();
        test_silence();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
